// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one transaction in flight, misaligned accesses answered with an error.
// Optional round-robin arbitration when DMEM_ARB_RR_EN is defined; fixed priority (port 0) otherwise.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [3:0]        p0_be,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p0_rready,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [3:0]        p1_be,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    input  logic              p1_rready,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic              owner_we;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              any_req;
    logic              sel;
    logic              accept;
    logic              aligned;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [3:0]        acc_be;
    logic              owner_rready;
    logic              in_resp;

    assign any_req = p0_req | p1_req;

`ifdef DMEM_ARB_RR_EN
    logic last_gnt;

    // On contention the port that did not win last time is chosen.
    assign sel = (p0_req && p1_req) ? ~last_gnt : p1_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= sel;
        end
    end
`else
    assign sel = ~p0_req & p1_req;
`endif

    assign accept    = (state == IDLE) && any_req && !rst;
    assign p0_gnt    = accept && !sel;
    assign p1_gnt    = accept && sel;

    assign acc_we    = sel ? p1_we    : p0_we;
    assign acc_addr  = sel ? p1_addr  : p0_addr;
    assign acc_wdata = sel ? p1_wdata : p0_wdata;
    assign acc_be    = sel ? p1_be    : p0_be;
    assign aligned   = (acc_addr[1:0] == 2'b00);

    // Memory is strobed only in the accept cycle of an aligned request.
    assign mem_en    = accept && aligned;
    assign mem_we    = mem_en && acc_we;
    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;
    assign mem_be    = acc_be;

    assign owner_rready = owner ? p1_rready : p0_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            owner_we <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= sel;
                        owner_we <= acc_we;
                        if (aligned) begin
                            state <= DATA;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state   <= RESP;
                        end
                    end
                end
                DATA: begin
                    rdata_q <= owner_we ? '0 : mem_rdata;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                RESP: begin
                    if (owner_rready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_resp   = (state == RESP);
    assign p0_rvalid = in_resp && !owner;
    assign p1_rvalid = in_resp && owner;
    assign p0_rdata  = p0_rvalid ? rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rdata_q : '0;
    assign p0_err    = p0_rvalid && err_q;
    assign p1_err    = p1_rvalid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table plus arbitration, backpressure and reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err, p0_rready;
    logic [4:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic [3:0]  p0_be;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err, p1_rready;
    logic [4:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic [3:0]  p1_be;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [8] = '{32'h0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0C0C0C0C,
                             32'h0, 32'h0, 32'h0, 32'h0};

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_mem_en;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];
    int   grants [4];
    int   exp_g [4];

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p0_rready(p0_rready),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .p1_rready(p1_rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[4:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[4:2]];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_port(input logic port, input logic req, input logic we,
                              input logic [4:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int   lat;
        logic got;
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata, v.be);
        @(negedge clk);
        checkOutput("gnt", v.port ? p1_gnt : p0_gnt, 1);
        checkOutput("other_gnt", v.port ? p0_gnt : p1_gnt, 0);
        checkOutput("mem_en", mem_en, v.exp_mem_en);
        if (v.exp_mem_en) begin
            checkOutput("mem_we", mem_we, v.we);
            checkOutput("mem_be", mem_be, v.be);
            checkOutput("mem_addr", mem_addr, v.addr);
            if (v.we) checkOutput("mem_wdata", mem_wdata, v.wdata);
        end
        @(posedge clk); #1;
        drive_port(v.port, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        got = 1'b0;
        for (lat = 1; lat <= 6; lat++) begin
            @(negedge clk);
            if (v.port ? p1_rvalid : p0_rvalid) begin
                got = 1'b1;
                break;
            end
            checkOutput("mem_en_busy", mem_en, 0);
        end
        checkOutput("rvalid_timeout", got, 1);
        checkOutput("latency", lat, v.exp_lat);
        checkOutput("rdata", v.port ? p1_rdata : p0_rdata, v.exp_rdata);
        checkOutput("err", v.port ? p1_err : p0_err, v.exp_err);
        checkOutput("other_rvalid", v.port ? p0_rvalid : p1_rvalid, 0);
        checkOutput("other_rdata", v.port ? p0_rdata : p1_rdata, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        int   n;
        int   got;

        vecs[0]  = '{1'b0, 1'b0, 5'd4,  32'h0,        4'hF, 1'b1, 2, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 5'd8,  32'h11223344, 4'h3, 1'b1, 2, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd8,  32'h0,        4'hF, 1'b1, 2, 32'hA5A53344, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 5'd6,  32'h0,        4'hF, 1'b0, 1, 32'h0,        1'b1};
        vecs[4]  = '{1'b1, 1'b0, 5'd9,  32'h0,        4'hF, 1'b0, 1, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b1, 5'd12, 32'hFFFFFFFF, 4'h0, 1'b1, 2, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5'd12, 32'h0,        4'hF, 1'b1, 2, 32'h0C0C0C0C, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 5'd16, 32'hCAFEF00D, 4'hF, 1'b1, 2, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 1'b0, 5'd16, 32'h0,        4'hF, 1'b1, 2, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 5'd0,  32'h12345678, 4'hC, 1'b1, 2, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 1'b1, 5'd3,  32'hFFFFFFFF, 4'hF, 1'b0, 1, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        4'hF, 1'b1, 2, 32'h12340000, 1'b0};
`ifdef DMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif

        rst = 1'b1;
        p0_rready = 1'b1; p1_rready = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        drive_port(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);

        // Requests during reset must be ignored.
        #1 drive_port(1'b0, 1'b1, 1'b0, 5'd4, 32'h0, 4'hF);
        @(negedge clk);
        checkOutput("rst_gnt", p0_gnt, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_rvalid", p0_rvalid, 0);
        checkOutput("rst_rdata", p0_rdata, 0);
        checkOutput("rst_err", p0_err, 0);
        @(posedge clk); #1;
        drive_port(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // Continuous contention: grant order depends on the arbitration mode.
        do_reset();
        drive_port(1'b0, 1'b1, 1'b0, 5'd4, 32'h0, 4'hF);
        drive_port(1'b1, 1'b1, 1'b0, 5'd16, 32'h0, 4'hF);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            checkOutput("dual_gnt", {31'b0, p0_gnt & p1_gnt}, 0);
            if (p0_gnt || p1_gnt) begin
                grants[n] = p1_gnt ? 1 : 0;
                n++;
            end
            @(posedge clk); #1;
        end
        drive_port(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        drive_port(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("grant_count", n, 4);
        for (int i = 0; i < 4 && i < n; i++) checkOutput("grant_order", grants[i], exp_g[i]);

        // Response backpressure: p0 holds rready low while p1 waits.
        do_reset();
        p0_rready = 1'b0;
        drive_port(1'b0, 1'b1, 1'b0, 5'd4, 32'h0, 4'hF);
        drive_port(1'b1, 1'b1, 1'b0, 5'd16, 32'h0, 4'hF);
        @(negedge clk);
        checkOutput("bp_p0_gnt", p0_gnt, 1);
        checkOutput("bp_p1_gnt", p1_gnt, 0);
        @(posedge clk); #1;
        drive_port(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("bp_data_p1_gnt", p1_gnt, 0);
        checkOutput("bp_data_rvalid", p0_rvalid, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_hold_rvalid", p0_rvalid, 1);
            checkOutput("bp_hold_rdata", p0_rdata, 32'hDEADBEEF);
            checkOutput("bp_hold_p1_gnt", p1_gnt, 0);
            checkOutput("bp_hold_p1_rvalid", p1_rvalid, 0);
            @(posedge clk); #1;
        end
        p0_rready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_rvalid", p0_rvalid, 1);
        checkOutput("bp_release_p1_gnt", p1_gnt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bp_after_p1_gnt", p1_gnt, 1);
        @(posedge clk); #1;
        drive_port(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        got = 0;
        for (int c = 0; c < 6 && got == 0; c++) begin
            @(negedge clk);
            if (p1_rvalid) got = 1;
        end
        checkOutput("bp_p1_timeout", got, 1);
        checkOutput("bp_p1_rdata", p1_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Reset while a response is pending drops it immediately.
        do_reset();
        p0_rready = 1'b0;
        drive_port(1'b0, 1'b1, 1'b0, 5'd4, 32'h0, 4'hF);
        @(posedge clk); #1;
        drive_port(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rr_resp_rvalid", p0_rvalid, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rr_rst_rvalid", p0_rvalid, 0);
        checkOutput("rr_rst_rdata", p0_rdata, 0);
        checkOutput("rr_rst_err", p0_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        p0_rready = 1'b1;
        v = '{1'b0, 1'b0, 5'd4, 32'h0, 4'hF, 1'b1, 2, 32'hDEADBEEF, 1'b0};
        applyStimulus(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
